// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the pipeline MEM stage (CPU port)
// and a debug/loader port (DBG port). Every access is a three-cycle
// transaction: accept (IDLE), memory strobe (SERVE), acknowledge (ACK).
// Arbitration is round-robin between the two ports. Misaligned and
// out-of-range addresses never strobe the memory. They complete with err set.
//
// Parameters
//   WORDS   depth of the attached memory in 32-bit words
//   ADDR_W  byte-address width
//   DATA_W  data width
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_ack
//   cpu_rdata           registered read data, valid from the ack cycle on
//   cpu_ack, cpu_err    one-cycle completion pulse, error flag with it
//   cpu_stall           cpu_req & ~cpu_ack, freezes the pipeline
//   dbg_*               debug port, same meaning as the CPU port (no stall)
//   mem_read/mem_write  DataMemory MemRead / MemWrite strobes
//   mem_addr/mem_wdata  DataMemory RWAddress / DataIn
//   mem_rdata           DataMemory DataOut (combinational read path)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int WORDS  = 14,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic              cpu_stall,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              dbg_err,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_ACK   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_t;

   // First word index beyond the memory, at address width.
   localparam logic [ADDR_W-1:0] WORDS_LIMIT = ADDR_W'(WORDS);

   state_t            state_q, state_d;
   port_t             last_q, last_d;
   port_t             port_q, port_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic              cpu_err_q, cpu_err_d;
   logic              dbg_err_q, dbg_err_d;

   // Winner of the current arbitration and its request fields.
   port_t             grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_err;

   // ---------------------------------------------------------------------------
   // Round-robin arbitration: on a tie the port not served last wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant = PORT_CPU;
      if (cpu_req && dbg_req) begin
         grant = (last_q == PORT_CPU) ? PORT_DBG : PORT_CPU;
      end else if (dbg_req) begin
         grant = PORT_DBG;
      end

      sel_we    = (grant == PORT_DBG) ? dbg_we    : cpu_we;
      sel_addr  = (grant == PORT_DBG) ? dbg_addr  : cpu_addr;
      sel_wdata = (grant == PORT_DBG) ? dbg_wdata : cpu_wdata;
      sel_err   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= WORDS_LIMIT);
   end

   // ---------------------------------------------------------------------------
   // Next-state and register-input logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets its default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      last_d      = last_q;
      port_d      = port_q;
      we_d        = we_q;
      err_d       = err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      cpu_err_d   = 1'b0;
      dbg_err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cpu_req || dbg_req) begin
               port_d  = grant;
               last_d  = grant;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               err_d   = sel_err;
               state_d = S_SERVE;
            end
         end

         S_SERVE: begin
            // Reads capture the memory output; an illegal read returns zero.
            if (!we_q) begin
               if (port_q == PORT_CPU) begin
                  cpu_rdata_d = err_q ? '0 : mem_rdata;
               end else begin
                  dbg_rdata_d = err_q ? '0 : mem_rdata;
               end
            end
            cpu_ack_d = (port_q == PORT_CPU);
            dbg_ack_d = (port_q == PORT_DBG);
            cpu_err_d = (port_q == PORT_CPU) && err_q;
            dbg_err_d = (port_q == PORT_DBG) && err_q;
            state_d   = S_ACK;
         end

         // The requester's req is still high from the finished access here,
         // so arbitrating now would serve it twice.
         S_ACK: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset wins over every _d, so an access aborted in SERVE
   // neither captures data nor acknowledges.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only in clocked blocks, so every flop
      // samples the pre-edge value of the others.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_q      <= PORT_DBG;
         port_q      <= PORT_CPU;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         dbg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         port_q      <= port_d;
         we_q        <= we_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         cpu_err_q   <= cpu_err_d;
         dbg_err_q   <= dbg_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. The strobes are gated with rst_n directly so a write in flight
   // when reset arrives never reaches the memory.
   // ---------------------------------------------------------------------------
   assign mem_read  = (state_q == S_SERVE) && !we_q && !err_q && rst_n;
   assign mem_write = (state_q == S_SERVE) &&  we_q && !err_q && rst_n;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_err   = cpu_err_q;
   assign cpu_stall = cpu_req && !cpu_ack_q;

   assign dbg_rdata = dbg_rdata_q;
   assign dbg_ack   = dbg_ack_q;
   assign dbg_err   = dbg_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives dmem_arbiter with directed transactions followed by two randomized
// requesters. A transaction-level model (acceptance time, round-robin pointer,
// a mirror of memory contents) predicts every output on every cycle. Directed
// sections add literal expectations for latency, stall, errors and reset.
// Inputs change 2 time units after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int WORDS = 14;
   localparam bit P_CPU = 1'b0;
   localparam bit P_DBG = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_ack, dbg_err;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.WORDS(WORDS), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0011;
   endfunction

   // ---------------- DataMemory stand-in: async read, write at the edge -------
   logic [31:0] dmem [WORDS];
   bit          dmem_ready = 1'b0;

   always @(posedge clk) begin
      if (!dmem_ready) begin
         for (int i = 0; i < WORDS; i++) dmem[i] <= init_word(i);
         dmem_ready <= 1'b1;
      end else if (mem_write && (mem_addr[31:2] < 30'(WORDS))) begin
         dmem[mem_addr[5:2]] <= mem_wdata;
      end
   end

   assign mem_rdata = (mem_addr[31:2] < 30'(WORDS)) ? dmem[mem_addr[5:2]] : 32'h0;

   // ---------------- checking helpers -----------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic cyc_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic cyc_sample();
      @(negedge clk);
   endtask

   task automatic drive(input bit port, input bit req, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == P_CPU) begin
         cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end
   endtask

   // Waits for the port's ack, starting with the current cycle. Returns the
   // number of cycles waited (0 = ack now), or -1 when the bound expires.
   task automatic wait_ack(input bit port, output int n);
      n = -1;
      for (int k = 0; k < 20; k++) begin
         cyc_sample();
         if ((port == P_CPU) ? cpu_ack : dbg_ack) begin
            n = k;
            break;
         end
         cyc_drive();
      end
      check("ack within 20 cycles", 32'(n < 0), 32'd0);
   endtask

   // One complete access on an otherwise quiet port pair.
   task automatic single(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int stalls,
                         output bit saw_rd, output bit saw_wr,
                         output logic [31:0] strobe_addr, output logic [31:0] rd,
                         output bit er);
      lat = -1; stalls = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      strobe_addr = '0; rd = '0; er = 1'b0;
      cyc_drive();
      drive(port, 1'b1, we, addr, wdata);
      for (int n = 0; n < 20; n++) begin
         cyc_sample();
         if (cpu_stall) stalls++;
         if (mem_read || mem_write) strobe_addr = mem_addr;
         saw_rd |= mem_read;
         saw_wr |= mem_write;
         if ((port == P_CPU) ? cpu_ack : dbg_ack) begin
            lat = n;
            rd  = (port == P_CPU) ? cpu_rdata : dbg_rdata;
            er  = (port == P_CPU) ? cpu_err   : dbg_err;
            break;
         end
         cyc_drive();
      end
      cyc_drive();
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r = int'($urandom_range(0, 9));
      if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      if (r == 1) return 32'h0000_0038 + 32'($urandom_range(0, 3)) * 32'd4;
      if (r == 2) return 32'hFFFF_FFFC;
      return 32'($urandom_range(0, WORDS - 1)) * 32'd4;
   endfunction

   task automatic rand_port(input bit port, input int nops);
      int got;
      for (int i = 0; i < nops; i++) begin
         int gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            cyc_drive();
            drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         cyc_drive();
         drive(port, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
         wait_ack(port, got);
      end
      cyc_drive();
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // ---------------- transaction-level reference model ------------------------
   // A request accepted in cycle t strobes memory in t+1 and is acknowledged
   // in t+2; the arbiter is free again from t+3.
   function automatic bit addr_illegal(input logic [31:0] a);
      return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(WORDS));
   endfunction

   bit          m_valid = 1'b0;
   bit          m_busy  = 1'b0;
   bit          m_last  = P_DBG;
   bit          m_port, m_we, m_err;
   int          m_t0    = 0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_crd   = '0;
   logic [31:0] m_drd   = '0;
   logic [31:0] ref_mem [WORDS];
   bit          ref_ready = 1'b0;

   always @(negedge clk) begin : compare
      int  age;
      bit  e_rd, e_wr, e_cack, e_dack, e_cerr, e_derr, win;
      if (!ref_ready) begin
         for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
         ref_ready = 1'b1;
      end
      age = cyc - m_t0;
      e_rd = 1'b0; e_wr = 1'b0; e_cack = 1'b0; e_dack = 1'b0; e_cerr = 1'b0; e_derr = 1'b0;
      if (m_busy && age == 1) begin
         e_rd = !m_we && !m_err && (rst_n === 1'b1);
         e_wr =  m_we && !m_err && (rst_n === 1'b1);
      end
      if (m_busy && age == 2) begin
         e_cack = (m_port == P_CPU);
         e_dack = (m_port == P_DBG);
         e_cerr = e_cack && m_err;
         e_derr = e_dack && m_err;
      end

      if (m_valid) begin
         check("mdl mem_read",  32'(mem_read),  32'(e_rd));
         check("mdl mem_write", 32'(mem_write), 32'(e_wr));
         check("mdl mem_addr",  mem_addr,  m_addr);
         check("mdl mem_wdata", mem_wdata, m_wdata);
         check("mdl cpu_ack",   32'(cpu_ack), 32'(e_cack));
         check("mdl dbg_ack",   32'(dbg_ack), 32'(e_dack));
         check("mdl cpu_err",   32'(cpu_err), 32'(e_cerr));
         check("mdl dbg_err",   32'(dbg_err), 32'(e_derr));
         check("mdl cpu_rdata", cpu_rdata, m_crd);
         check("mdl dbg_rdata", dbg_rdata, m_drd);
         check("mdl cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
      end

      if (rst_n !== 1'b1) begin
         m_valid = 1'b1; m_busy = 1'b0; m_last = P_DBG;
         m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0;
      end else if (m_valid) begin
         if (m_busy && age == 1) begin
            if (m_we && !m_err) ref_mem[m_addr[5:2]] = m_wdata;
            if (!m_we) begin
               if (m_port == P_CPU) m_crd = m_err ? 32'h0 : ref_mem[m_addr[5:2]];
               else                 m_drd = m_err ? 32'h0 : ref_mem[m_addr[5:2]];
            end
         end else if (m_busy && age == 2) begin
            m_busy = 1'b0;
         end else if (!m_busy && (cpu_req || dbg_req)) begin
            if (cpu_req && dbg_req) win = (m_last == P_CPU) ? P_DBG : P_CPU;
            else                    win = cpu_req ? P_CPU : P_DBG;
            m_port  = win;
            m_last  = win;
            m_we    = (win == P_CPU) ? cpu_we    : dbg_we;
            m_addr  = (win == P_CPU) ? cpu_addr  : dbg_addr;
            m_wdata = (win == P_CPU) ? cpu_wdata : dbg_wdata;
            m_err   = addr_illegal(m_addr);
            m_t0    = cyc;
            m_busy  = 1'b1;
         end
      end
   end

   // ---------------- watchdog --------------------------------------------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequences, then random traffic ------------------
   initial begin
      int          lat, st, got;
      bit          sr, sw, er;
      logic [31:0] sa, rd;
      int          ca [2];
      int          da [2];
      int          nc, nd, stall_hi, stall_at2;
      logic [31:0] c_rd, d_rd1, d_rd2;

      rst_n = 1'b0;
      drive(P_CPU, 1'b1, 1'b0, 32'h0, 32'h0);
      drive(P_DBG, 1'b1, 1'b0, 32'h4, 32'h0);

      // Reset with both requests high: everything zero, stall follows cpu_req.
      for (int r = 0; r < 2; r++) begin
         cyc_drive();
         cyc_sample();
         check("rst strobes/acks/errs", {26'h0, mem_read, mem_write, cpu_ack, dbg_ack, cpu_err, dbg_err}, 32'h0);
         check("rst mem_addr",  mem_addr,  32'h0);
         check("rst mem_wdata", mem_wdata, 32'h0);
         check("rst cpu_rdata", cpu_rdata, 32'h0);
         check("rst dbg_rdata", dbg_rdata, 32'h0);
         check("rst cpu_stall", 32'(cpu_stall), 32'd1);
      end

      // Release: CPU (addr 0x0) must win over DBG (addr 0x4).
      cyc_drive();
      rst_n = 1'b1;
      cyc_sample();
      cyc_drive();
      cyc_sample();
      check("first grant mem_read", 32'(mem_read), 32'd1);
      check("first grant is CPU",   mem_addr, 32'h0);
      cyc_drive();
      cyc_sample();
      check("first cpu_ack", 32'(cpu_ack), 32'd1);
      check("first no dbg_ack", 32'(dbg_ack), 32'd0);
      check("first cpu_rdata", cpu_rdata, init_word(0));
      cyc_drive();
      drive(P_CPU, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_ack(P_DBG, got);
      check("dbg after cpu latency", 32'(got), 32'd2);
      check("dbg_rdata word1", dbg_rdata, init_word(1));
      cyc_drive();
      drive(P_DBG, 1'b0, 1'b0, 32'h0, 32'h0);

      // Simultaneous requests, CPU re-requests at once, DBG re-requests at once.
      cyc_drive();
      drive(P_CPU, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
      drive(P_DBG, 1'b1, 1'b0, 32'h8, 32'h0);
      ca[0] = -1; ca[1] = -1; da[0] = -1; da[1] = -1;
      nc = 0; nd = 0; stall_hi = 0; stall_at2 = 1;
      c_rd = '0; d_rd1 = '0; d_rd2 = '0;
      for (int n = 0; n < 12; n++) begin
         bit c_now, d_now;
         cyc_sample();
         c_now = cpu_ack;
         d_now = dbg_ack;
         if (n >= 3 && n <= 5 && cpu_stall) stall_hi++;
         if (n == 2) stall_at2 = cpu_stall;
         if (c_now && nc < 2) begin ca[nc] = n; if (nc == 1) c_rd = cpu_rdata; nc++; end
         if (d_now && nd < 2) begin da[nd] = n; if (nd == 0) d_rd1 = dbg_rdata; else d_rd2 = dbg_rdata; nd++; end
         cyc_drive();
         if (c_now) drive(P_CPU, (nc == 1), 1'b0, 32'h10, 32'h0);
         if (d_now) drive(P_DBG, (nd == 1), 1'b0, 32'h10, 32'h0);
      end
      check("pair1 cpu_ack cycle", 32'(ca[0]), 32'd2);
      check("pair1 dbg_ack cycle", 32'(da[0]), 32'd5);
      check("pair2 cpu_ack cycle", 32'(ca[1]), 32'd8);
      check("pair2 dbg_ack cycle", 32'(da[1]), 32'd11);
      check("stall low in ack cycle", 32'(stall_at2), 32'd0);
      check("stall high behind dbg", 32'(stall_hi), 32'd3);
      check("pair dbg read 0x8",  d_rd1, init_word(2));
      check("pair cpu read 0x10", c_rd,  32'hCAFE_F00D);
      check("pair dbg read 0x10", d_rd2, 32'hCAFE_F00D);

      // CPU write then read of 0x8.
      single(P_CPU, 1'b1, 32'h8, 32'hDEAD_BEEF, lat, st, sr, sw, sa, rd, er);
      check("wr latency",   32'(lat), 32'd2);
      check("wr stall",     32'(st),  32'd2);
      check("wr strobe",    32'(sw),  32'd1);
      check("wr no read",   32'(sr),  32'd0);
      check("wr addr",      sa, 32'h8);
      check("wr err",       32'(er),  32'd0);
      check("wr memory",    dmem[2], 32'hDEAD_BEEF);
      single(P_CPU, 1'b0, 32'h8, 32'h0, lat, st, sr, sw, sa, rd, er);
      check("rd latency",   32'(lat), 32'd2);
      check("rd stall",     32'(st),  32'd2);
      check("rd strobe",    32'(sr),  32'd1);
      check("rd data",      rd, 32'hDEAD_BEEF);

      // Illegal addresses.
      single(P_DBG, 1'b0, 32'h6, 32'h0, lat, st, sr, sw, sa, rd, er);
      check("misaligned latency",  32'(lat), 32'd2);
      check("misaligned no read",  32'(sr),  32'd0);
      check("misaligned dbg_err",  32'(er),  32'd1);
      check("misaligned rdata",    rd, 32'h0);
      single(P_CPU, 1'b1, 32'h38, 32'h1111_1111, lat, st, sr, sw, sa, rd, er);
      check("range latency",  32'(lat), 32'd2);
      check("range no write", 32'(sw),  32'd0);
      check("range cpu_err",  32'(er),  32'd1);

      // Reset during the SERVE cycle of a write.
      cyc_drive();
      drive(P_CPU, 1'b1, 1'b1, 32'h4, 32'h1234_5678);
      cyc_sample();
      cyc_drive();
      rst_n = 1'b0;
      cyc_sample();
      check("abort mem_write gated", 32'(mem_write), 32'd0);
      check("abort addr latched",    mem_addr, 32'h4);
      cyc_drive();
      rst_n = 1'b1;
      drive(P_CPU, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc_sample();
      check("abort no cpu_ack", 32'(cpu_ack), 32'd0);
      check("abort word1 kept", dmem[1], init_word(1));
      check("abort mem_addr",   mem_addr, 32'h0);
      check("abort cpu_rdata",  cpu_rdata, 32'h0);
      for (int n = 0; n < 2; n++) begin
         cyc_drive();
         cyc_sample();
         check("abort ack stays low", 32'(cpu_ack), 32'd0);
      end

      // Fields changed after acceptance are ignored.
      single(P_CPU, 1'b1, 32'h0, 32'hA5A5_0000, lat, st, sr, sw, sa, rd, er);
      check("post-reset latency", 32'(lat), 32'd2);
      cyc_drive();
      drive(P_CPU, 1'b1, 1'b0, 32'h0, 32'h0);
      cyc_sample();
      cyc_drive();
      cpu_addr = 32'hC;
      cyc_sample();
      check("late change mem_read", 32'(mem_read), 32'd1);
      check("late change mem_addr", mem_addr, 32'h0);
      cyc_drive();
      cyc_sample();
      check("late change ack",   32'(cpu_ack), 32'd1);
      check("late change rdata", cpu_rdata, 32'hA5A5_0000);
      cyc_drive();
      drive(P_CPU, 1'b0, 1'b0, 32'h0, 32'h0);

      // Random traffic from both ports against the model.
      fork
         rand_port(P_CPU, 80);
         rand_port(P_DBG, 80);
      join
      repeat (4) begin
         cyc_drive();
         cyc_sample();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
